// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shadows NUM_STAGES in-flight destinations and picks per-source forward selects / stall.
// Optional perf counters (StallCnt, FwdCnt) are enabled by defining FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LAT_W      = 2,
    parameter int SEL_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ID_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ID_rs,
    input  logic [NUM_SRC-1:0]        ID_rs_used,
    input  logic [REG_AW-1:0]         ID_rd,
    input  logic                      ID_we,
    input  logic [LAT_W-1:0]          ID_lat,
    input  logic                      Hold,
    input  logic                      Flush,
    output logic [NUM_SRC*SEL_W-1:0]  Fwd,
    output logic                      Stall
`ifdef FWD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]               StallCnt,
    output logic [31:0]               FwdCnt
`endif
);

    // Index 0 is stage 1 (EX); index k is stage k+1.
    logic [NUM_STAGES-1:0] vQ;
    logic [REG_AW-1:0]     rdQ  [NUM_STAGES];
    logic [LAT_W-1:0]      cntQ [NUM_STAGES];
    logic                  issue;

    always_comb begin
        logic found;
        Fwd   = '0;
        Stall = 1'b0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            // Ascending scan: the first hit is the youngest producer, older ones are masked.
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (!found && ID_valid && ID_rs_used[i] && vQ[k] &&
                    (rdQ[k] != '0) && (rdQ[k] == ID_rs[i*REG_AW +: REG_AW])) begin
                    found = 1'b1;
                    if (cntQ[k] == '0) begin
                        Fwd[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end else begin
                        Stall = 1'b1;
                    end
                end
            end
        end
    end

    assign issue = ID_valid & ~Stall & ~Hold & ~Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vQ <= '0;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                rdQ[k]  <= '0;
                cntQ[k] <= '0;
            end
        end else if (!Hold) begin
            vQ[0]   <= issue & ID_we & (ID_rd != '0);
            rdQ[0]  <= ID_rd;
            cntQ[0] <= ID_lat;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                // A flushed EX instruction is killed rather than carried into MEM.
                vQ[k]   <= vQ[k-1] & ~(Flush & (k == 1));
                rdQ[k]  <= rdQ[k-1];
                cntQ[k] <= (cntQ[k-1] == '0) ? '0 : cntQ[k-1] - LAT_W'(1);
            end
        end else if (Flush) begin
            vQ[0] <= 1'b0;
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FwdCnt   <= '0;
        end else begin
            if (ID_valid && Stall && !Hold) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (issue && (Fwd != '0)) begin
                FwdCnt <= FwdCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed vector table, async reset sequence, random run vs queue model.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_valid;
    logic [9:0]  ID_rs;
    logic [1:0]  ID_rs_used;
    logic [4:0]  ID_rd;
    logic        ID_we;
    logic [1:0]  ID_lat;
    logic        Hold;
    logic        Flush;
    logic [3:0]  Fwd;
    logic        Stall;
`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0] StallCnt;
    logic [31:0] FwdCnt;
`endif

    fwd_scoreboard #(.NUM_SRC(2), .REG_AW(5), .NUM_STAGES(3), .LAT_W(2), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rs_used(ID_rs_used),
        .ID_rd(ID_rd), .ID_we(ID_we), .ID_lat(ID_lat), .Hold(Hold), .Flush(Flush),
        .Fwd(Fwd), .Stall(Stall)
`ifdef FWD_SCOREBOARD_PERF_EN
        , .StallCnt(StallCnt), .FwdCnt(FwdCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       we;
        logic [1:0] lat;
        logic       hold;
        logic       flush;
        logic [3:0] expFwd;
        logic       expStall;
    } vec_t;

    // Model: each in-flight producer knows its rd, its latency and how many stages it has reached.
    typedef struct {
        int rd;
        int lat;
        int stage;
    } prod_t;

    prod_t       pipe[$];
    int          total = 0;
    int          bad = 0;
    int unsigned mStall = 0;
    int unsigned mFwd = 0;
    vec_t        tab[27];

    function automatic vec_t mk(int valid, int rs0, int rs1, int used, int rd, int we, int lat,
                                int hold, int flush, int expFwd, int expStall);
        vec_t v;
        v.valid = 1'(valid);   v.rs0 = 5'(rs0);     v.rs1 = 5'(rs1);  v.used = 2'(used);
        v.rd = 5'(rd);         v.we = 1'(we);       v.lat = 2'(lat);  v.hold = 1'(hold);
        v.flush = 1'(flush);   v.expFwd = 4'(expFwd); v.expStall = 1'(expStall);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A result is forwardable once the producer has advanced at least lat stages past EX.
    function automatic void modelEval(input vec_t v, output logic [3:0] fwd, output logic stall);
        int rs;
        int best;
        bit ready;
        fwd = '0;
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? int'(v.rs0) : int'(v.rs1);
            best = 0;
            ready = 1'b0;
            foreach (pipe[j]) begin
                if (v.valid && v.used[i] && rs != 0 && pipe[j].rd == rs &&
                    (best == 0 || pipe[j].stage < best)) begin
                    best = pipe[j].stage;
                    ready = (pipe[j].lat <= pipe[j].stage - 1);
                end
            end
            if (best != 0) begin
                if (ready) fwd[i*2 +: 2] = 2'(best);
                else stall = 1'b1;
            end
        end
    endfunction

    function automatic void modelStep(input vec_t v, input logic stall, input logic [3:0] fwd);
        prod_t nq[$];
        prod_t p;
        prod_t n;
        bit issue;
        issue = v.valid && !stall && !v.hold && !v.flush;
        if (v.valid && stall && !v.hold) mStall++;
        if (issue && fwd != 4'd0) mFwd++;
        foreach (pipe[j]) begin
            p = pipe[j];
            if (!(v.flush && p.stage == 1)) begin
                if (!v.hold) p.stage++;
                if (p.stage <= 3) nq.push_back(p);
            end
        end
        if (!v.hold && issue && v.we && v.rd != 5'd0) begin
            n.rd = int'(v.rd);
            n.lat = int'(v.lat);
            n.stage = 1;
            nq.push_front(n);
        end
        pipe = nq;
    endfunction

    task automatic drive(input vec_t v);
        ID_valid = v.valid;  ID_rs = {v.rs1, v.rs0};  ID_rs_used = v.used;
        ID_rd = v.rd;        ID_we = v.we;            ID_lat = v.lat;
        Hold = v.hold;       Flush = v.flush;
    endtask

    task automatic applyCycle(input vec_t v, input bit useTab, input string name);
        logic [3:0] ef;
        logic       es;
        drive(v);
        #1;
        modelEval(v, ef, es);
        check({name, " fwd"}, 32'(Fwd), 32'(ef));
        check({name, " stall"}, 32'(Stall), 32'(es));
        if (useTab) begin
            check({name, " tabFwd"}, 32'(Fwd), 32'(v.expFwd));
            check({name, " tabStall"}, 32'(Stall), 32'(v.expStall));
        end
        @(posedge clk);
        modelStep(v, es, ef);
        #1;
    endtask

    initial begin
        //             vld rs0 rs1 used rd we lat hold flush fwd stall
        tab[0]  = mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);  // ALU producer rd5
        tab[1]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tab[2]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        tab[3]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 3, 0);
        tab[4]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tab[5]  = mk(1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);  // load rd7
        tab[6]  = mk(1, 0, 7, 2, 0, 0, 0, 0, 0, 0, 1);
        tab[7]  = mk(1, 0, 7, 2, 0, 0, 0, 0, 0, 8, 0);
        tab[8]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);  // priority
        tab[9]  = mk(1, 3, 0, 1, 3, 1, 0, 0, 0, 1, 0);
        tab[10] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tab[11] = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        tab[12] = mk(1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        tab[13] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tab[14] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        tab[15] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // zero register
        tab[16] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tab[17] = mk(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);  // flush
        tab[18] = mk(1, 9, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        tab[19] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tab[20] = mk(1, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0);  // hold with lat 2
        tab[21] = mk(1, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        tab[22] = mk(1, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        tab[23] = mk(1, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        tab[24] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tab[25] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tab[26] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 3, 0);

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset fwd", 32'(Fwd), 32'd0);
        check("reset stall", 32'(Stall), 32'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 27; t++) begin
            applyCycle(tab[t], 1'b1, $sformatf("vec%0d", t));
        end

        // Async reset in the middle of a pending stall.
        applyCycle(mk(1, 0, 0, 0, 6, 1, 3, 0, 0, 0, 0), 1'b1, "rstIssue");
        drive(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("preRst stall", 32'(Stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncRst stall", 32'(Stall), 32'd0);
        check("asyncRst fwd", 32'(Fwd), 32'd0);
`ifdef FWD_SCOREBOARD_PERF_EN
        check("asyncRst stallCnt", StallCnt, 32'd0);
        check("asyncRst fwdCnt", FwdCnt, 32'd0);
`endif
        pipe.delete();
        mStall = 0;
        mFwd = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyCycle(mk(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0), 1'b1, "postRstIssue");
        applyCycle(mk(1, 8, 8, 3, 0, 0, 0, 0, 0, 5, 0), 1'b1, "postRstFwd");

        for (int t = 0; t < 400; t++) begin
            vec_t v;
            v = mk(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 6) == 0), int'($urandom_range(0, 9) == 0),
                   0, 0);
            applyCycle(v, 1'b0, "rand");
        end

`ifdef FWD_SCOREBOARD_PERF_EN
        check("stallCnt", StallCnt, mStall);
        check("fwdCnt", FwdCnt, mFwd);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational forwarding unit; sits alongside the ID stage.
- Tracks in-flight destination registers in an internal shadow pipeline of NUM_STAGES entries (stage 1 = EX, 2 = MEM, 3 = WB, ...).
- Per source operand, outputs a forward select to the youngest matching producer.
- Raises a stall (load-use and multi-cycle results) when that producer's result is not yet forwardable.
- Supports pipeline hold and flush.

Parameters:
- NUM_SRC, 2, number of source operands checked per ID instruction.
- REG_AW, 5, register address width.
- NUM_STAGES, 3, tracked stages after ID (EX..WB).
- LAT_W, 2, width of the producer latency field.
- SEL_W, 2, forward select width; must hold NUM_STAGES (default 2 bits covers 0..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_valid  in  1  ID holds a valid instruction.
- ID_rs  in  NUM_SRC*REG_AW  packed source addresses; src i at bits [i*REG_AW +: REG_AW].
- ID_rs_used  in  NUM_SRC  src i is actually read.
- ID_rd  in  REG_AW  destination address.
- ID_we  in  1  instruction writes rd.
- ID_lat  in  LAT_W  advances after EX before the result can be forwarded (0 = ALU, 1 = load, ...).
- Hold  in  1  downstream freeze: scoreboard does not advance.
- Flush  in  1  kill stage-1 entry and ID issue (branch redirect).
- Fwd  out  NUM_SRC*SEL_W  per-source select; 0 = regfile, k = stage k.
- Stall  out  1  ID must not issue this cycle.

Behaviour:
- Reset (rst_n low, async): all entries invalid, counters cleared. Fwd = 0 and Stall = 0 immediately.
- Entry k (1..NUM_STAGES) holds {v, rd, cnt}.
- Match for src i at stage k: ID_valid & ID_rs_used[i] & v_k & (rd_k != 0) & (rd_k == rs_i).
- Priority: the lowest matching k (youngest) wins, and older matches are ignored.
  - Winner with cnt_k == 0: Fwd_i = k.
  - Winner with cnt_k != 0: Fwd_i = 0 and the source is blocked.
  - No match: Fwd_i = 0.
- Stall = any source blocked. Combinational from the inputs and current state, same cycle.
- Issue = ID_valid & ~Stall & ~Hold & ~Flush.
- Advance when Hold = 0, on the rising edge:
  - entry k+1 <= entry k, with cnt decremented and saturating at 0;
  - entry NUM_STAGES is discarded;
  - entry 1 <= {Issue & ID_we & (ID_rd != 0), ID_rd, ID_lat}.
  - A stall inserts a bubble (v = 0) into stage 1.
- When Hold = 1: all entries keep their value and cnt does not decrement. Fwd and Stall keep being evaluated combinationally.
- Flush = 1, Hold = 0: stage-1 entry becomes invalid on this edge (the instruction in EX is killed); stages 2..N advance normally; nothing is issued.
- Flush = 1, Hold = 1: Flush wins for stage 1 (its v is cleared); stages 2..N hold.
- Simultaneous same-rd producers in multiple stages: the youngest decides, including its stall.
- rd = 0 is never tracked; rs = 0 never matches.
- Fwd latency: 0 cycles (combinational). Stall release: the cycle after the blocking entry's cnt reaches 0 in its current stage, provided no younger match remains.
- Reset asserted mid-operation clears all entries immediately. First issue is allowed on the first edge after release.

Optional Feature:
- Macro FWD_SCOREBOARD_PERF_EN.
- Defined:
  - adds outputs StallCnt (32 bits) and FwdCnt (32 bits), both reset to 0;
  - StallCnt increments each clk with ID_valid & Stall & ~Hold;
  - FwdCnt increments each clk in which any Fwd_i != 0 and Issue = 1;
  - both counters wrap modulo 2^32.
- Undefined: no counter ports and no counter logic.

Test Plan:
- ALU dependency: issue rd = 5 with lat 0, then next cycle ID rs1 = 5 -> Fwd_0 = 1, Stall = 0. Cycle after that, rs1 = 5 -> Fwd_0 = 2. Next -> 3. Next -> 0.
- Load-use: issue rd = 7 with lat 1, then ID rs2 = 7 -> Stall = 1 for one cycle with a bubble in stage 1. Next cycle Fwd_1 = 2, Stall = 0.
- Priority: stage 1 rd = 3 (cnt 0) and stage 2 rd = 3 -> Fwd_0 = 1. Stage 1 rd = 3 with cnt 1 and stage 2 rd = 3 with cnt 0 -> Stall = 1 (youngest blocks).
- Zero register: issue rd = 0 with ID_we = 1, then rs1 = 0 -> Fwd = 0, Stall = 0.
- Hold/Flush: stall pending with lat 2, assert Hold for 3 cycles -> cnt frozen and Stall stays 1. Flush with stage-1 rd = 9 -> next cycle rs = 9 gives Fwd = 0.
- Async reset: assert rst_n = 0 mid-stall, between clock edges -> Stall = 0 and Fwd = 0 immediately. With FWD_SCOREBOARD_PERF_EN defined, StallCnt = 0.
